// File: rtl/eth_decap_mc.sv
// rtl/eth_decap_mc.sv - NetTLP-over-UDP decapsulator demuxing payload beats into per-channel TLP FIFOs
// din layout: [74] tvalid, [73] tuser, [72] tlast, [71:64] tkeep, [63:0] tdata
module eth_decap_mc #(
  parameter int unsigned NUM_CH      = 4,
  parameter logic [47:0] LOCAL_MAC   = 48'h00_11_22_33_44_55,
  parameter bit          CHK_MAC     = 1'b0,
  parameter logic [31:0] LOCAL_IP    = {8'd192, 8'd168, 8'd10, 8'd1},
  parameter logic [31:0] REMOTE_IP   = {8'd192, 8'd168, 8'd10, 8'd3},
  parameter logic [15:0] REMOTE_PORT = 16'h3776,
  parameter logic [15:0] PORT_BASE   = 16'h3776
) (
  input  logic              eth_clk,
  input  logic              eth_rst_n,
  input  logic              eth_tvalid,
  input  logic              eth_tlast,
  input  logic [7:0]        eth_tkeep,
  input  logic [63:0]       eth_tdata,
  input  logic              eth_tuser,
  output logic [NUM_CH-1:0] wr_en,
  output logic [74:0]       din,
  input  logic [NUM_CH-1:0] full,
  output logic [NUM_CH-1:0] fifo_read_req,
  output logic [31:0]       cnt_ok,
  output logic [31:0]       cnt_drop_hdr,
  output logic [31:0]       cnt_drop_full
);

  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [15:0] NUM_CH16 = 16'(NUM_CH);

  typedef enum logic [3:0] {
    S_HDR0, S_HDR1, S_HDR2, S_HDR3, S_HDR4, S_HDR5,
    S_PAYLOAD, S_FULL_WAIT, S_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [15:0]     daddr_hi_q, daddr_hi_d;
  logic            tlast_seen_q, tlast_seen_d;
  logic [31:0]     cnt_ok_q, cnt_ok_d;
  logic [31:0]     cnt_drop_hdr_q, cnt_drop_hdr_d;
  logic [31:0]     cnt_drop_full_q, cnt_drop_full_d;

  logic [15:0] dport;
  logic [15:0] dport_off;
  logic [63:0] swapped;
  logic        sel_full;
  logic        in_hdr;
  logic        hdr_ok;
  state_t      hdr_next;
  logic        wr;
  logic        rreq;
  logic        unused_tuser;

  // tuser carries no meaning on the receive side
  assign unused_tuser = eth_tuser;

  // Wire bytes 36/37 of the frame sit in bytes 4/5 of header beat 4
  assign dport     = {eth_tdata[39:32], eth_tdata[47:40]};
  assign dport_off = dport - PORT_BASE;
  assign sel_full  = full[ch_q];

  // Each 32-bit half is byte-reversed in place for the TLP FIFO word order
  assign swapped = {eth_tdata[39:32], eth_tdata[47:40], eth_tdata[55:48], eth_tdata[63:56],
                    eth_tdata[7:0],   eth_tdata[15:8],  eth_tdata[23:16], eth_tdata[31:24]};

  assign cnt_ok        = cnt_ok_q;
  assign cnt_drop_hdr  = cnt_drop_hdr_q;
  assign cnt_drop_full = cnt_drop_full_q;

  // Header checks on the arriving beat, frame state transitions and the zero-latency write
  always_comb begin
    state_d         = state_q;
    ch_d            = ch_q;
    daddr_hi_d      = daddr_hi_q;
    tlast_seen_d    = tlast_seen_q;
    cnt_ok_d        = cnt_ok_q;
    cnt_drop_hdr_d  = cnt_drop_hdr_q;
    cnt_drop_full_d = cnt_drop_full_q;
    in_hdr          = 1'b0;
    hdr_ok          = 1'b1;
    hdr_next        = S_HDR0;
    wr              = 1'b0;
    rreq            = 1'b0;
    din             = '0;
    case (state_q)
      S_HDR0: begin
        in_hdr   = 1'b1;
        hdr_next = S_HDR1;
        hdr_ok   = !CHK_MAC ||
                   ({eth_tdata[7:0], eth_tdata[15:8], eth_tdata[23:16],
                     eth_tdata[31:24], eth_tdata[39:32], eth_tdata[47:40]} == LOCAL_MAC);
      end
      S_HDR1: begin
        in_hdr   = 1'b1;
        hdr_next = S_HDR2;
        hdr_ok   = ({eth_tdata[39:32], eth_tdata[47:40]} == 16'h0800) &&
                   (eth_tdata[55:48] == 8'h45);
      end
      S_HDR2: begin
        in_hdr   = 1'b1;
        hdr_next = S_HDR3;
        hdr_ok   = (eth_tdata[63:56] == 8'd17);
      end
      S_HDR3: begin
        in_hdr   = 1'b1;
        hdr_next = S_HDR4;
        hdr_ok   = ({eth_tdata[23:16], eth_tdata[31:24], eth_tdata[39:32], eth_tdata[47:40]}
                    == REMOTE_IP);
        // Upper half of daddr straddles into the next beat
        if (eth_tvalid) daddr_hi_d = {eth_tdata[55:48], eth_tdata[63:56]};
      end
      S_HDR4: begin
        in_hdr   = 1'b1;
        hdr_next = S_HDR5;
        hdr_ok   = ({daddr_hi_q, eth_tdata[7:0], eth_tdata[15:8]} == LOCAL_IP) &&
                   ({eth_tdata[23:16], eth_tdata[31:24]} == REMOTE_PORT) &&
                   (dport_off < NUM_CH16);
        if (eth_tvalid) ch_d = dport_off[CH_W-1:0];
      end
      S_HDR5: begin
        in_hdr   = 1'b1;
        hdr_next = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (eth_tvalid) begin
          if (!sel_full) begin
            wr  = 1'b1;
            din = {1'b1, 1'b0, eth_tlast, eth_tkeep, swapped};
            if (eth_tlast) begin
              rreq     = 1'b1;
              cnt_ok_d = cnt_ok_q + 32'd1;
              state_d  = S_HDR0;
            end
          end else begin
            cnt_drop_full_d = cnt_drop_full_q + 32'd1;
            tlast_seen_d    = eth_tlast;
            state_d         = S_FULL_WAIT;
          end
        end
      end
      S_FULL_WAIT: begin
        if (!sel_full) begin
          // Close the truncated TLP with an empty tlast beat
          wr           = 1'b1;
          rreq         = 1'b1;
          din          = {1'b1, 1'b0, 1'b1, 8'h00, 64'h0};
          tlast_seen_d = 1'b0;
          state_d      = (tlast_seen_q || (eth_tvalid && eth_tlast)) ? S_HDR0 : S_DRAIN;
        end else if (eth_tvalid && eth_tlast) begin
          tlast_seen_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (eth_tvalid && eth_tlast) state_d = S_HDR0;
      end
      default: state_d = S_HDR0;
    endcase
    // A failed check or a runt costs exactly one header drop per frame
    if (in_hdr && eth_tvalid) begin
      if (!hdr_ok || eth_tlast) begin
        cnt_drop_hdr_d = cnt_drop_hdr_q + 32'd1;
        state_d        = eth_tlast ? S_HDR0 : S_DRAIN;
      end else begin
        state_d = hdr_next;
      end
    end
  end

  // Steer the write and close strobes onto the latched channel only
  always_comb begin
    wr_en               = '0;
    fifo_read_req       = '0;
    wr_en[ch_q]         = wr;
    fifo_read_req[ch_q] = rreq;
  end

  // State and counter registers
  always_ff @(posedge eth_clk or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      state_q         <= S_HDR0;
      ch_q            <= '0;
      daddr_hi_q      <= '0;
      tlast_seen_q    <= 1'b0;
      cnt_ok_q        <= '0;
      cnt_drop_hdr_q  <= '0;
      cnt_drop_full_q <= '0;
    end else begin
      state_q         <= state_d;
      ch_q            <= ch_d;
      daddr_hi_q      <= daddr_hi_d;
      tlast_seen_q    <= tlast_seen_d;
      cnt_ok_q        <= cnt_ok_d;
      cnt_drop_hdr_q  <= cnt_drop_hdr_d;
      cnt_drop_full_q <= cnt_drop_full_d;
    end
  end

endmodule

// File: tb/tb_eth_decap_mc.sv
// tb/tb_eth_decap_mc.sv - directed bench for eth_decap_mc with a frame-level reference model
`timescale 1ns/1ps
module tb_eth_decap_mc;
  localparam int          NUM_CH    = 4;
  localparam logic [15:0] PORT_BASE = 16'h3776;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              tvalid, tlast, tuser;
  logic [7:0]        tkeep;
  logic [63:0]       tdata;
  logic [NUM_CH-1:0] wr_en, full, rreq;
  logic [74:0]       din;
  logic [31:0]       cnt_ok, cnt_hdr, cnt_full;

  always #5 clk = ~clk;

  eth_decap_mc #(.NUM_CH(NUM_CH)) dut (
    .eth_clk(clk), .eth_rst_n(rst_n), .eth_tvalid(tvalid), .eth_tlast(tlast),
    .eth_tkeep(tkeep), .eth_tdata(tdata), .eth_tuser(tuser),
    .wr_en(wr_en), .din(din), .full(full), .fifo_read_req(rreq),
    .cnt_ok(cnt_ok), .cnt_drop_hdr(cnt_hdr), .cnt_drop_full(cnt_full)
  );

  int                n_vec = 0;
  int                n_err = 0;
  bit                chk_en = 1'b0;
  logic [NUM_CH-1:0] exp_wr, exp_rreq;
  logic [74:0]       exp_din;
  int                obs_wr[NUM_CH];
  int                obs_rreq[NUM_CH];
  logic [63:0]       obs_data[$];
  int                m_ok, m_hdr, m_full;
  byte unsigned      frm[$];
  int                snap_w, snap_r, snap_d, snap_tot;

  task automatic check(input string name, input logic [74:0] act, input logic [74:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int total_writes();
    int s = 0;
    for (int c = 0; c < NUM_CH; c++) s += obs_wr[c];
    return s;
  endfunction

  // Per-cycle compare of the FIFO-side outputs against the model expectation
  always @(negedge clk) begin
    if (chk_en) begin
      check("wr_en", 75'(wr_en), 75'(exp_wr));
      check("fifo_read_req", 75'(rreq), 75'(exp_rreq));
      check("din", din, exp_din);
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_en[c]) begin
          obs_wr[c]++;
          obs_data.push_back(din[63:0]);
        end
        if (rreq[c]) obs_rreq[c]++;
      end
    end
  end

  function automatic logic [63:0] swap_words(input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int h = 0; h < 2; h++)
      for (int i = 0; i < 4; i++)
        r[32*h + 8*(3-i) +: 8] = d[32*h + 8*i +: 8];
    return r;
  endfunction

  // Whole-frame verdict: target channel, or -1 for a header drop
  function automatic int frame_channel();
    logic [15:0] off;
    if (frm.size() <= 48) return -1;
    if (frm[12] != 8'h08 || frm[13] != 8'h00 || frm[14] != 8'h45 || frm[23] != 8'd17) return -1;
    if ({frm[26], frm[27], frm[28], frm[29]} != 32'hC0A8_0A03) return -1;
    if ({frm[30], frm[31], frm[32], frm[33]} != 32'hC0A8_0A01) return -1;
    if ({frm[34], frm[35]} != 16'h3776) return -1;
    off = {frm[36], frm[37]} - PORT_BASE;
    if (int'(off) >= NUM_CH) return -1;
    return int'(off);
  endfunction

  task automatic build(input logic [15:0] dport, input logic [7:0] proto, input int pay_len);
    logic [383:0] hv;
    hv = {48'h0011_2233_4455, 48'h0200_0000_0001, 16'h0800, 8'h45, 8'h00,
          16'h0040, 16'h0000, 16'h4000, 8'h40, proto, 16'h0000,
          32'hC0A8_0A03, 32'hC0A8_0A01, 16'h3776, dport, 16'h0020, 16'h0000, 48'h0};
    frm.delete();
    for (int i = 0; i < 48; i++) frm.push_back(hv[383 - 8*i -: 8]);
    for (int i = 0; i < pay_len; i++)
      frm.push_back((i < 8) ? 8'(8'h11 * (i + 1)) : 8'(i * 7 + 3));
  endtask

  task automatic get_beat(input int b, output logic [63:0] d, output logic [7:0] k);
    d = '0;
    k = '0;
    for (int i = 0; i < 8; i++)
      if (8*b + i < frm.size()) begin
        d[8*i +: 8] = frm[8*b + i];
        k[i]        = 1'b1;
      end
  endtask

  task automatic idle();
    tvalid = 1'b0; tlast = 1'b0; tkeep = '0; tdata = '0; full = '0;
    exp_wr = '0; exp_rreq = '0; exp_din = '0;
  endtask

  task automatic check_cnt();
    check_i("cnt_ok", int'(cnt_ok), m_ok);
    check_i("cnt_drop_hdr", int'(cnt_hdr), m_hdr);
    check_i("cnt_drop_full", int'(cnt_full), m_full);
  endtask

  // Present frm, predicting every cycle's FIFO-side outputs from the frame verdict
  task automatic run_frame(input int gaps, input int full_beat, input int full_len,
                           input bit other_full, input int nsend);
    int nbeats, send, ch, beat, cyc, full_left, guard;
    bit trunc, flushed, present, sel_full;
    logic [63:0] d;
    logic [7:0]  k;
    logic [NUM_CH-1:0] mask;
    nbeats = (frm.size() + 7) / 8;
    send   = (nsend < 0) ? nbeats : nsend;
    ch     = frame_channel();
    mask   = (ch >= 0) ? (NUM_CH'(1) << ch) : '0;
    beat = 0; cyc = 0; full_left = 0; guard = 0; trunc = 1'b0; flushed = 1'b0;
    while ((beat < send || (trunc && !flushed)) && guard < 200) begin
      @(posedge clk); #1;
      present = (beat < send) && !(gaps != 0 && cyc % 3 == 1);
      if (present && beat == full_beat) full_left = full_len;
      sel_full = (full_left > 0);
      if (full_left > 0) full_left--;
      full   = (sel_full ? mask : '0) | (other_full ? ~mask : '0);
      tvalid = present;
      d = '0; k = '0;
      if (present) begin
        get_beat(beat, d, k);
        tdata = d; tkeep = k; tlast = (beat == nbeats - 1);
      end else begin
        tdata = 64'hDEAD_BEEF_0BAD_F00D; tkeep = 8'hFF; tlast = 1'b1;
      end
      exp_wr = '0; exp_rreq = '0; exp_din = '0;
      if (ch >= 0) begin
        if (!trunc && present && beat >= 6) begin
          if (!sel_full) begin
            exp_wr  = mask;
            exp_din = {1'b1, 1'b0, tlast, k, swap_words(d)};
            if (tlast) begin
              exp_rreq = mask;
              m_ok++;
            end
          end else begin
            trunc = 1'b1;
            m_full++;
          end
        end else if (trunc && !flushed && !sel_full) begin
          exp_wr   = mask;
          exp_rreq = mask;
          exp_din  = {1'b1, 1'b0, 1'b1, 8'h00, 64'h0};
          flushed  = 1'b1;
        end
      end
      if (present) beat++;
      cyc++;
      guard++;
    end
    if (guard >= 200) check_i("frame_cycle_budget", guard, 0);
    if (ch < 0 && nsend < 0) m_hdr++;
    if (nsend < 0) begin
      @(posedge clk); #1;
      idle();
      check_cnt();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] d;
    logic [7:0]  k;
    rst_n = 1'b0; tuser = 1'b1;
    idle();
    m_ok = 0; m_hdr = 0; m_full = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check_cnt();
    check("din_reset", din, 75'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ch2 frame, 4 payload beats with gaps, other channels' full held high
    snap_w = obs_wr[2]; snap_r = obs_rreq[2]; snap_d = obs_data.size();
    build(PORT_BASE + 16'd2, 8'd17, 32);
    run_frame(1, -1, 0, 1'b1, -1);
    check_i("ch2_writes", obs_wr[2] - snap_w, 4);
    check_i("ch2_read_req", obs_rreq[2] - snap_r, 1);
    check_i("cnt_ok_first", int'(cnt_ok), 1);
    if (obs_data.size() > snap_d) check("swap_first_beat", 75'(obs_data[snap_d]), 75'(64'h5566778811223344));
    else check("swap_first_beat", 75'h0, 75'(64'h5566778811223344));

    // dport one past the last channel is rejected, next frame still accepted
    snap_tot = total_writes();
    build(PORT_BASE + 16'd4, 8'd17, 24);
    run_frame(0, -1, 0, 1'b0, -1);
    check_i("bad_dport_writes", total_writes() - snap_tot, 0);
    check_i("bad_dport_drop", int'(cnt_hdr), 1);
    build(PORT_BASE, 8'd17, 16);
    run_frame(1, -1, 0, 1'b0, -1);
    check_i("after_reject_ok", int'(cnt_ok), 2);

    // ch1 full at second payload beat for 3 cycles
    snap_w = obs_wr[1];
    build(PORT_BASE + 16'd1, 8'd17, 32);
    run_frame(0, 7, 3, 1'b0, -1);
    check_i("ch1_trunc_writes", obs_wr[1] - snap_w, 2);
    check_i("ch1_drop_full", int'(cnt_full), 1);

    // 40-byte runt ending in header beat 4
    build(PORT_BASE + 16'd3, 8'd17, 0);
    while (frm.size() > 40) void'(frm.pop_back());
    run_frame(0, -1, 0, 1'b0, -1);
    check_i("runt40_drop", int'(cnt_hdr), 2);

    // wrong IP protocol, then exact 48-byte header-only runt
    build(PORT_BASE + 16'd3, 8'd6, 24);
    run_frame(1, -1, 0, 1'b0, -1);
    build(PORT_BASE + 16'd1, 8'd17, 0);
    run_frame(0, -1, 0, 1'b0, -1);
    check_i("proto_runt48_drop", int'(cnt_hdr), 4);

    // partial last beat on ch3, then full on the tlast beat of a ch0 frame
    build(PORT_BASE + 16'd3, 8'd17, 21);
    run_frame(1, -1, 0, 1'b1, -1);
    build(PORT_BASE, 8'd17, 24);
    run_frame(1, 8, 2, 1'b0, -1);
    check_i("tlast_full_drop", int'(cnt_full), 2);

    // reset in the middle of a ch0 payload
    build(PORT_BASE, 8'd17, 40);
    run_frame(0, -1, 0, 1'b0, 8);
    @(posedge clk); #1;
    get_beat(8, d, k);
    tdata = d; tkeep = k; tvalid = 1'b1; tlast = 1'b0;
    exp_wr = '0; exp_rreq = '0; exp_din = '0;
    rst_n = 1'b0;
    m_ok = 0; m_hdr = 0; m_full = 0;
    #1;
    check("rst_wr_en", 75'(wr_en), 75'h0);
    check("rst_read_req", 75'(rreq), 75'h0);
    check("rst_din", din, 75'h0);
    check_cnt();
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (72) void'(frm.pop_front());
    snap_tot = total_writes();
    run_frame(0, -1, 0, 1'b0, -1);
    check_i("post_reset_writes", total_writes() - snap_tot, 0);
    check_i("post_reset_drop", int'(cnt_hdr), 1);
    build(PORT_BASE + 16'd2, 8'd17, 8);
    run_frame(0, -1, 0, 1'b0, -1);
    check_i("post_reset_ok", int'(cnt_ok), 1);

    repeat (2) @(posedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
